// File: rtl/tdc_meas_ctrl.sv
// rtl/tdc_meas_ctrl.sv - TDC measurement sequencer: arm/start/stop FSM, time-word calc, timeout, error count
// Optional macro TDC_AUTO_REARM_EN: re-arm straight from DONE after each accepted result.
module tdc_meas_ctrl #(
  parameter int                  COARSE_W     = 16,
  parameter int                  FINE_W       = 8,
  parameter int                  BINS_PER_CLK = 64,
  parameter logic [COARSE_W-1:0] TIMEOUT_CYC  = 16'hFFF0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       start_in,
  input  logic                       stop_in,
  input  logic [COARSE_W-1:0]        coarse_in,
  input  logic [FINE_W-1:0]          fine_in,
  output logic                       hit,
  output logic                       coarse_clr,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [COARSE_W+FINE_W-1:0] res_time,
  output logic                       res_timeout,
  output logic [7:0]                 err_cnt
);

  localparam int TW = COARSE_W + FINE_W;

  typedef enum logic [2:0] {IDLE, ARMED, RUN, CALC, DONE} state_t;

  state_t              state_q;
  logic [2:0]          start_sync_q;
  logic [2:0]          stop_sync_q;
  logic                start_stb;
  logic                stop_stb;
  logic [FINE_W-1:0]   fine_start_q;
  logic [FINE_W-1:0]   fine_stop_q;
  logic [COARSE_W-1:0] coarse_q;
  logic                hit_q;
  logic                coarse_clr_q;
  logic                res_valid_q;
  logic                res_timeout_q;
  logic [TW-1:0]       res_time_q;
  logic [TW-1:0]       calc_time_d;
  logic [TW:0]         calc_tmp;
  logic [7:0]          err_cnt_q;
  logic [7:0]          err_cnt_d;

  // Bits [1:0] are the synchronizer, bit [2] holds the previous synchronized value.
  assign start_stb = start_sync_q[1] & ~start_sync_q[2];
  assign stop_stb  = stop_sync_q[1] & ~stop_sync_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start_in};
      stop_sync_q  <= {stop_sync_q[1:0], stop_in};
    end
  end

  // Bit TW of the signed intermediate flags a stop code that outran the coarse count.
  always_comb begin
    calc_tmp    = (TW+1)'(coarse_q) * (TW+1)'(BINS_PER_CLK)
                + (TW+1)'(fine_start_q) - (TW+1)'(fine_stop_q);
    calc_time_d = calc_tmp[TW] ? '0 : calc_tmp[TW-1:0];
    err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      fine_start_q  <= '0;
      fine_stop_q   <= '0;
      coarse_q      <= '0;
      hit_q         <= 1'b0;
      coarse_clr_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_time_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      coarse_clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm) begin
            coarse_clr_q <= 1'b1;
            state_q      <= ARMED;
          end
        end
        ARMED: begin
          if (abort) begin
            hit_q   <= 1'b0;
            state_q <= IDLE;
          end else if (start_stb) begin
            fine_start_q <= fine_in;
            hit_q        <= 1'b1;
            state_q      <= RUN;
          end else if (stop_stb) begin
            err_cnt_q <= err_cnt_d;
          end
        end
        RUN: begin
          if (abort) begin
            hit_q   <= 1'b0;
            state_q <= IDLE;
          end else if (stop_stb) begin
            fine_stop_q <= fine_in;
            coarse_q    <= coarse_in;
            hit_q       <= 1'b0;
            state_q     <= CALC;
          end else if (coarse_in == TIMEOUT_CYC) begin
            hit_q         <= 1'b0;
            res_time_q    <= '1;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            err_cnt_q     <= err_cnt_d;
            state_q       <= DONE;
          end
        end
        CALC: begin
          if (abort) begin
            hit_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            res_time_q    <= calc_time_d;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
`ifdef TDC_AUTO_REARM_EN
            coarse_clr_q <= 1'b1;
            state_q      <= ARMED;
`else
            state_q      <= IDLE;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit         = hit_q;
  assign coarse_clr  = coarse_clr_q;
  assign busy        = (state_q != IDLE);
  assign res_valid   = res_valid_q;
  assign res_time    = res_time_q;
  assign res_timeout = res_timeout_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb/tb_tdc_meas_ctrl.sv - scoreboard bench for tdc_meas_ctrl with directed measurement vectors
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        start_in = 1'b0;
  logic        stop_in = 1'b0;
  logic [15:0] coarse_in = '0;
  logic [7:0]  fine_in = '0;
  logic        res_ready = 1'b1;
  logic        hit;
  logic        coarse_clr;
  logic        busy;
  logic        res_valid;
  logic [23:0] res_time;
  logic        res_timeout;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int clr_cycles = 0;
  int valid_cycles = 0;
  logic [24:0] exp_q[$];

  tdc_meas_ctrl dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .start_in(start_in), .stop_in(stop_in),
    .coarse_in(coarse_in), .fine_in(fine_in),
    .hit(hit), .coarse_clr(coarse_clr), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_time(res_time), .res_timeout(res_timeout), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    step(4);
    start_in = 1'b0;
    step(3);
  endtask

  task automatic pulse_stop();
    stop_in = 1'b1;
    step(4);
    stop_in = 1'b0;
    step(3);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step(1);
      n++;
    end
    if (exp_q.size() != 0) check({name, "_result_timeout"}, exp_q.size(), 0);
    step(1);
  endtask

  // Scoreboard monitor: compares every presented result, pops on acceptance.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (coarse_clr) clr_cycles++;
      if (res_valid) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {7'd0, res_timeout, res_time}, 32'hDEAD);
        end else begin
          check("result", {7'd0, res_timeout, res_time}, {7'd0, exp_q[0]});
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    step(3);
    check("reset_outputs", {hit, coarse_clr, busy, res_valid, res_timeout, res_time, err_cnt}, 0);
    rst = 1'b1;
    step(2);
    check("idle_busy", busy, 0);

    // Basic measurement: 10*64 + 20 - 5 = 655
    clr_cycles = 0;
    valid_cycles = 0;
    do_arm();
    check("arm_coarse_clr", coarse_clr, 1);
    check("arm_busy", busy, 1);
    fine_in = 8'd20;
    pulse_start();
    check("basic_hit_high", hit, 1);
    fine_in = 8'd5;
    coarse_in = 16'd10;
    exp_q.push_back({1'b0, 24'd655});
    pulse_stop();
    wait_drain("basic");
    check("basic_valid_cycles", valid_cycles, 1);
    check("basic_clr_cycles", clr_cycles, 1);
    check("basic_idle", busy, 0);
    check("basic_hit_low", hit, 0);

    // Backpressure: 3*64 + 0 - 0 = 192, edges in DONE ignored
    res_ready = 1'b0;
    do_arm();
    fine_in = 8'd0;
    pulse_start();
    coarse_in = 16'd3;
    exp_q.push_back({1'b0, 24'd192});
    stop_in = 1'b1;
    step(4);
    stop_in = 1'b0;
    begin
      int n = 0;
      while (!res_valid && n < 10) begin step(1); n++; end
    end
    check("bp_valid_seen", res_valid, 1);
    start_in = 1'b1;
    step(2);
    stop_in = 1'b1;
    step(2);
    start_in = 1'b0;
    stop_in = 1'b0;
    step(3);
    check("bp_still_valid", res_valid, 1);
    check("bp_hit_low", hit, 0);
    res_ready = 1'b1;
    step(1);
    check("bp_valid_drop", res_valid, 0);
    check("bp_idle", busy, 0);
    check("bp_err_unchanged", err_cnt, 0);
    check("bp_scoreboard_empty", exp_q.size(), 0);
    step(3);

    // Stray stops, then simultaneous start/stop: 2*64 + 7 - 7 = 128
    do_arm();
    for (int i = 0; i < 3; i++) pulse_stop();
    check("stray_err_cnt", err_cnt, 3);
    check("stray_still_armed", {busy, hit}, 2'b10);
    fine_in = 8'd7;
    start_in = 1'b1;
    stop_in = 1'b1;
    step(4);
    start_in = 1'b0;
    stop_in = 1'b0;
    step(3);
    check("simul_hit", hit, 1);
    check("simul_err_cnt", err_cnt, 3);
    check("simul_no_result", res_valid, 0);
    coarse_in = 16'd2;
    exp_q.push_back({1'b0, 24'd128});
    pulse_stop();
    wait_drain("simul");

    // Timeout
    do_arm();
    fine_in = 8'd0;
    coarse_in = 16'd0;
    pulse_start();
    check("to_hit", hit, 1);
    exp_q.push_back({1'b1, 24'hFFFFFF});
    for (int i = 0; i <= 8; i++) begin
      coarse_in = 16'hFFE8 + 16'(i);
      step(1);
    end
    check("to_hit_low", hit, 0);
    wait_drain("timeout");
    check("to_err_cnt", err_cnt, 4);
    coarse_in = 16'd0;

    // Negative clamp: 0*64 + 3 - 40 < 0
    do_arm();
    fine_in = 8'd3;
    pulse_start();
    fine_in = 8'd40;
    exp_q.push_back({1'b0, 24'd0});
    pulse_stop();
    wait_drain("clamp");

    // Abort in RUN
    do_arm();
    pulse_start();
    check("abort_pre_hit", hit, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_hit", hit, 0);
    check("abort_idle", busy, 0);
    step(8);
    check("abort_no_result", res_valid, 0);
    check("abort_err_cnt", err_cnt, 4);

    // Reset while in CALC
    do_arm();
    fine_in = 8'd1;
    pulse_start();
    coarse_in = 16'd1;
    stop_in = 1'b1;
    step(3);
    check("calc_state", {busy, hit, res_valid}, 3'b100);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {hit, coarse_clr, busy, res_valid, res_timeout, res_time, err_cnt}, 0);
    step(2);
    stop_in = 1'b0;
    rst = 1'b1;
    step(6);
    check("post_reset_idle", {busy, res_valid}, 0);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
- Measurement sequencer for the TDC datapath (coarse counter, fine delay line, fine decoder).
- Arms on request, detects start/stop edges, and drives the hit window and coarse-counter clear.
- Captures the fine code at both edges, combines coarse and fine into one time word, and presents it on a valid/ready result port.
- Enforces a timeout and keeps a saturating error counter.

Parameters:
- COARSE_W, 16, coarse count width.
- FINE_W, 8, decoded fine code width.
- BINS_PER_CLK, 64, fine bins per tdc clock period (fine code range 0..BINS_PER_CLK-1).
- TIMEOUT_CYC, 16'hFFF0, coarse count at which a run is abandoned.

Ports:
- clk, input, 1, TDC clock; all logic on rising edge.
- rst, input, 1, asynchronous active-low reset.
- arm, input, 1, one-cycle request to start a measurement.
- abort, input, 1, cancel the measurement in progress.
- start_in, input, 1, raw asynchronous start signal.
- stop_in, input, 1, raw asynchronous stop signal.
- coarse_in, input, COARSE_W, count from the coarse counter.
- fine_in, input, FINE_W, decoded fine code, valid every cycle.
- hit, output, 1, measurement window to the coarse/fine datapath.
- coarse_clr, output, 1, one-cycle clear pulse to the coarse counter.
- busy, output, 1, state is not IDLE.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts the result.
- res_time, output, COARSE_W+FINE_W, combined interval in fine bins.
- res_timeout, output, 1, result came from a timeout.
- err_cnt, output, 8, saturating count of stray stops and timeouts.

Behaviour:
- Reset (rst=0, async): state IDLE; hit=0, coarse_clr=0, busy=0, res_valid=0, res_time=0, res_timeout=0, err_cnt=0; synchronizers cleared.
- Edge detection: start_in and stop_in each pass through a 2-flop synchronizer plus a previous-value flop. The edge strobe fires on sync=1 and prev=0, 3 cycles after the raw rise.
- IDLE: on arm=1, pulse coarse_clr for 1 cycle and go to ARMED. arm in any other state is ignored.
- ARMED:
  - Start strobe: latch fine_start=fine_in in the same cycle, hit=1 from the next cycle, go to RUN.
  - Stop strobe without start: stray stop; err_cnt+1 (saturating at 255); stay ARMED.
  - Start and stop strobes in the same cycle: start taken, stop discarded, not counted.
- RUN:
  - Stop strobe: latch fine_stop=fine_in and coarse_in, hit=0 next cycle, go to CALC.
  - Further start strobes in RUN are ignored.
  - coarse_in==TIMEOUT_CYC: hit=0, res_time=all ones, res_timeout=1, err_cnt+1, go to DONE.
- CALC (1 cycle):
  - tmp = coarse*BINS_PER_CLK + fine_start - fine_stop, computed in COARSE_W+FINE_W+1 bits signed.
  - Negative tmp clamps to 0; tmp above the res_time range saturates to all ones.
  - res_timeout=0; go to DONE.
- DONE:
  - res_valid=1; res_time and res_timeout held stable until res_valid&&res_ready.
  - On acceptance, res_valid=0 next cycle and state returns to IDLE.
  - Edge strobes in DONE are discarded.
- Latency: stop strobe to res_valid = 2 cycles; raw stop rise to res_valid = 5 cycles.
- abort=1:
  - In ARMED, RUN or CALC: hit=0 and go to IDLE next cycle; no result, err_cnt unchanged.
  - In IDLE or DONE: ignored.
  - abort has priority over same-cycle edges.
- busy=1 in every state except IDLE.
- A new arm is only honoured once IDLE has been reached; back-to-back measurements need 1 idle cycle.

Optional Feature:
- Macro TDC_AUTO_REARM_EN.
- Defined: on result acceptance in DONE, go directly to ARMED with a coarse_clr pulse, with no arm needed. abort from ARMED still returns to IDLE.
- Undefined: DONE returns to IDLE, and arm is required for every measurement.

Test Plan:
- Basic measurement:
  - Stimulus: arm; start rise; coarse_in=10 at the stop strobe; fine_start=20, fine_stop=5; res_ready=1.
  - Response: coarse_clr pulses once; res_time=10*64+20-5=655; res_timeout=0; res_valid high exactly 1 cycle.
- Backpressure:
  - Stimulus: res_ready=0 for 7 cycles after res_valid, with a start and a stop rise inside that window.
  - Response: res_valid and res_time stable; the edges are ignored; IDLE on the cycle after res_ready=1.
- Timeout:
  - Stimulus: arm; start; no stop; coarse_in ramps to 16'hFFF0.
  - Response: hit falls; res_time=24'hFFFFFF; res_timeout=1; err_cnt=1.
- Stray and simultaneous edges:
  - Stimulus: 3 stops in ARMED, then start and stop rising together.
  - Response: err_cnt=3; state RUN; no result until a later stop.
- Abort and reset:
  - Stimulus: abort in RUN; separately, rst=0 in CALC.
  - Response: IDLE, hit=0, no res_valid. After reset, all outputs zero asynchronously.
- Negative clamp:
  - Stimulus: coarse=0, fine_start=3, fine_stop=40.
  - Response: res_time=0.
